// File: rtl/serial_rca_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 2-bit ripple-carry slice reused WIDTH/2 times with a registered carry.
// Optional subtract mode is compiled in with `define ADDSUB_EN (adds the Sub port).
module serial_rca_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ADDSUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int PASSES = WIDTH / 2;
  localparam int STEP_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [STEP_W-1:0] r_step;
  logic [WIDTH-1:0]  r_part;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic             w_accept;
  logic             w_last_step;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic             w_s0;
  logic             w_s1;
  logic             w_c1;
  logic             w_c2;
  logic [WIDTH-1:0] w_sum_final;

`ifdef ADDSUB_EN
  // Subtraction is A + ~B + 1, so inversion and forced carry happen once at latch time.
  assign w_b_in   = Sub ? ~B : B;
  assign w_cin_in = Sub ? 1'b1 : Cin;
`else
  assign w_b_in   = B;
  assign w_cin_in = Cin;
`endif

  assign w_accept    = Start && (r_state != S_RUN);
  assign w_last_step = (r_step == LAST_STEP);

  // The 2-bit ripple slice; w_c1 is the inter-bit carry, which on the last pass feeds the MSB.
  assign w_s0 = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c1 = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_s1 = r_a[1] ^ r_b[1] ^ w_c1;
  assign w_c2 = (r_a[1] & r_b[1]) | (w_c1 & (r_a[1] ^ r_b[1]));

  always_comb begin
    w_sum_final = r_part;
    w_sum_final[WIDTH-1 -: 2] = {w_s1, w_s0};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next_state = S_RUN;
      S_RUN:   if (w_last_step) w_next_state = S_DONE;
      S_DONE:  w_next_state = Start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (r_state)
      S_RUN:   Busy = 1'b1;
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_step  <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= w_b_in;
      r_carry <= w_cin_in;
      r_step  <= '0;
      r_part  <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 2;
      r_b     <= r_b >> 2;
      r_carry <= w_c2;
      r_step  <= r_step + 1'b1;
      r_part[{r_step, 1'b0} +: 2] <= {w_s1, w_s0};
      if (w_last_step) begin
        r_sum  <= w_sum_final;
        r_cout <= w_c2;
        r_ovf  <= w_c1 ^ w_c2;
      end
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;

endmodule
